// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - icache request/response and if2dec handshake bundle for ifu_fetch
interface ifu_fetch_if;
  logic        icache_req_vld_o;
  logic        icache_req_rdy_i;
  logic [31:0] icache_req_addr_o;
  logic        icache_rsp_vld_i;
  logic        icache_rsp_rdy_o;
  logic [31:0] icache_rsp_instr_i;
  logic        if2dec_vld_o;
  logic        if2dec_rdy_i;
  logic [31:0] if2dec_instr_o;
  logic [31:0] if2dec_pc_o;
  logic        if2dec_pc_j_o;
  logic        if2dec_prdt_taken_o;

  modport master (
    output icache_req_vld_o, icache_req_addr_o, icache_rsp_rdy_o,
    output if2dec_vld_o, if2dec_instr_o, if2dec_pc_o, if2dec_pc_j_o, if2dec_prdt_taken_o,
    input  icache_req_rdy_i, icache_rsp_vld_i, icache_rsp_instr_i, if2dec_rdy_i
  );

  modport slave (
    input  icache_req_vld_o, icache_req_addr_o, icache_rsp_rdy_o,
    input  if2dec_vld_o, if2dec_instr_o, if2dec_pc_o, if2dec_pc_j_o, if2dec_prdt_taken_o,
    output icache_req_rdy_i, icache_rsp_vld_i, icache_rsp_instr_i, if2dec_rdy_i
  );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - fetch PC, in-order icache requests, response FIFO toward decode
// Static BTFN prediction is built only when IFU_BTFN_PRDT_EN is defined.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_pc_i,
  ifu_fetch_if.master bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(BUF_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ifa_mem_q [BUF_DEPTH];
  logic [31:0]   ifa_mem_d [BUF_DEPTH];
  logic [PW-1:0] ifa_wr_q, ifa_wr_d, ifa_rd_q, ifa_rd_d;
  logic [31:0]   rb_instr_q [BUF_DEPTH];
  logic [31:0]   rb_instr_d [BUF_DEPTH];
  logic [31:0]   rb_pc_q [BUF_DEPTH];
  logic [31:0]   rb_pc_d [BUF_DEPTH];
  logic          rb_j_q [BUF_DEPTH];
  logic          rb_j_d [BUF_DEPTH];
  logic          rb_p_q [BUF_DEPTH];
  logic          rb_p_d [BUF_DEPTH];
  logic [PW-1:0] rb_wr_q, rb_wr_d, rb_rd_q, rb_rd_d;
  logic [CW-1:0] rb_occ_q, rb_occ_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] kill_cnt_q, kill_cnt_d;
`ifdef IFU_BTFN_PRDT_EN
  logic [CW-1:0] wp_cnt_q, wp_cnt_d;
  logic [31:0]   b_imm, j_imm, prdt_target;
  logic          prdt_taken;
`endif

  logic [CW:0]   used;
  logic [31:0]   rsp_pc, rsp_instr;
  logic          req_vld, req_fire, rsp_fire, rb_vld, pop;
  logic          push, push_j, push_p;

  // Credit counts both in-flight requests and buffered words so responses never overflow.
  assign used      = {1'b0, out_cnt_q} + {1'b0, rb_occ_q};
  assign req_vld   = rst & (used < DEPTH);
  assign req_fire  = req_vld & bus.icache_req_rdy_i;
  assign rsp_fire  = rst & bus.icache_rsp_vld_i;
  assign rb_vld    = rst & (rb_occ_q != '0);
  assign pop       = rb_vld & bus.if2dec_rdy_i;
  assign rsp_pc    = ifa_mem_q[ifa_rd_q];
  assign rsp_instr = bus.icache_rsp_instr_i;

`ifdef IFU_BTFN_PRDT_EN
  assign b_imm = {{19{rsp_instr[31]}}, rsp_instr[31], rsp_instr[7], rsp_instr[30:25],
                  rsp_instr[11:8], 1'b0};
  assign j_imm = {{11{rsp_instr[31]}}, rsp_instr[31], rsp_instr[19:12], rsp_instr[20],
                  rsp_instr[30:21], 1'b0};
  assign prdt_taken  = (rsp_instr[6:0] == 7'b1101111) ||
                       ((rsp_instr[6:0] == 7'b1100011) && rsp_instr[31]);
  assign prdt_target = rsp_pc + ((rsp_instr[6:0] == 7'b1101111) ? j_imm : b_imm);
`endif

  always_comb begin
    pc_d       = pc_q;
    ifa_mem_d  = ifa_mem_q;
    ifa_wr_d   = ifa_wr_q;
    ifa_rd_d   = ifa_rd_q;
    rb_instr_d = rb_instr_q;
    rb_pc_d    = rb_pc_q;
    rb_j_d     = rb_j_q;
    rb_p_d     = rb_p_q;
    rb_wr_d    = rb_wr_q;
    rb_rd_d    = rb_rd_q;
    rb_occ_d   = rb_occ_q;
    kill_cnt_d = kill_cnt_q;
`ifdef IFU_BTFN_PRDT_EN
    wp_cnt_d   = wp_cnt_q;
`endif
    push   = 1'b0;
    push_j = 1'b0;
    push_p = 1'b0;

    if (req_fire) begin
      ifa_mem_d[ifa_wr_q] = pc_q;
      ifa_wr_d            = ifa_wr_q + 1'b1;
      pc_d                = pc_q + 32'd4;
    end
    if (rsp_fire) begin
      ifa_rd_d = ifa_rd_q + 1'b1;
    end
    out_cnt_d = out_cnt_q + CW'(req_fire) - CW'(rsp_fire);

    if (rsp_fire) begin
      if (kill_cnt_q != '0) begin
        kill_cnt_d = kill_cnt_q - CW'(1'b1);
`ifdef IFU_BTFN_PRDT_EN
      end else if (wp_cnt_q != '0) begin
        push     = 1'b1;
        push_j   = 1'b1;
        wp_cnt_d = wp_cnt_q - CW'(1'b1);
`endif
      end else begin
        push = 1'b1;
`ifdef IFU_BTFN_PRDT_EN
        // Every request issued after this one, including one firing now, is wrong-path.
        if (prdt_taken) begin
          push_p   = 1'b1;
          pc_d     = prdt_target;
          wp_cnt_d = out_cnt_q - CW'(1'b1) + CW'(req_fire);
        end
`endif
      end
    end

    if (push && !jump_flag_i) begin
      rb_instr_d[rb_wr_q] = rsp_instr;
      rb_pc_d[rb_wr_q]    = rsp_pc;
      rb_j_d[rb_wr_q]     = push_j;
      rb_p_d[rb_wr_q]     = push_p;
      rb_wr_d             = rb_wr_q + 1'b1;
    end
    if (pop) begin
      rb_rd_d = rb_rd_q + 1'b1;
    end
    rb_occ_d = rb_occ_q + CW'(push && !jump_flag_i) - CW'(pop);

    // Redirect overrides prediction, flushes buffered words and kills everything still in flight.
    if (jump_flag_i) begin
      pc_d       = jump_pc_i;
      rb_rd_d    = rb_wr_q;
      rb_wr_d    = rb_wr_q;
      rb_occ_d   = '0;
      kill_cnt_d = out_cnt_d;
`ifdef IFU_BTFN_PRDT_EN
      wp_cnt_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      ifa_wr_q   <= '0;
      ifa_rd_q   <= '0;
      rb_wr_q    <= '0;
      rb_rd_q    <= '0;
      rb_occ_q   <= '0;
      out_cnt_q  <= '0;
      kill_cnt_q <= '0;
`ifdef IFU_BTFN_PRDT_EN
      wp_cnt_q   <= '0;
`endif
    end else begin
      pc_q       <= pc_d;
      ifa_wr_q   <= ifa_wr_d;
      ifa_rd_q   <= ifa_rd_d;
      rb_wr_q    <= rb_wr_d;
      rb_rd_q    <= rb_rd_d;
      rb_occ_q   <= rb_occ_d;
      out_cnt_q  <= out_cnt_d;
      kill_cnt_q <= kill_cnt_d;
`ifdef IFU_BTFN_PRDT_EN
      wp_cnt_q   <= wp_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    ifa_mem_q  <= ifa_mem_d;
    rb_instr_q <= rb_instr_d;
    rb_pc_q    <= rb_pc_d;
    rb_j_q     <= rb_j_d;
    rb_p_q     <= rb_p_d;
  end

  assign bus.icache_req_vld_o    = req_vld;
  assign bus.icache_req_addr_o   = pc_q;
  assign bus.icache_rsp_rdy_o    = rst;
  assign bus.if2dec_vld_o        = rb_vld;
  assign bus.if2dec_instr_o      = rb_vld ? rb_instr_q[rb_rd_q] : 32'h0;
  assign bus.if2dec_pc_o         = rb_vld ? rb_pc_q[rb_rd_q] : 32'h0;
  assign bus.if2dec_pc_j_o       = rb_vld & rb_j_q[rb_rd_q];
  assign bus.if2dec_prdt_taken_o = rb_vld & rb_p_q[rb_rd_q];
endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch with in-order 1-cycle icache model
module tb_ifu_fetch;
`ifdef IFU_BTFN_PRDT_EN
  localparam bit PRDT_EN = 1'b1;
`else
  localparam bit PRDT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_pc;
  logic        wrap_jump;
  logic [31:0] wrap_jpc;

  always #5 clk = ~clk;

  ifu_fetch_if bus_if();
  ifu_fetch_if wrap_if();

  ifu_fetch #(.RESET_PC(32'h8000_0000), .BUF_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag), .jump_pc_i(jump_pc), .bus(bus_if)
  );

  ifu_fetch #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) u_wrap (
    .clk(clk), .rst(rst), .jump_flag_i(wrap_jump), .jump_pc_i(wrap_jpc), .bus(wrap_if)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pc_j;
    logic        prdt;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        taken;
    logic [31:0] target;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  int          tests;
  int          fails;
  logic        hold;
  logic        rdy_en;
  logic [31:0] ov_addr;
  logic [31:0] ov_instr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == ov_addr) return ov_instr;
    return {a[26:2], 7'b0010011};
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  function automatic void push_exp(input logic [31:0] pc, input logic j, input logic p);
    exp_t e;
    e.pc    = pc;
    e.instr = mem(pc);
    e.pc_j  = j;
    e.prdt  = p;
    exp_q.push_back(e);
  endfunction

  task automatic drive();
    bus_if.icache_req_rdy_i = 1'b1;
    bus_if.icache_rsp_vld_i = !hold && (pend_q.size() > 0);
    if (pend_q.size() > 0) bus_if.icache_rsp_instr_i = mem(pend_q[0]);
    else bus_if.icache_rsp_instr_i = 32'h0;
    bus_if.if2dec_rdy_i = rdy_en && (exp_q.size() > 0);
  endtask

  task automatic sample();
    exp_t e;
    if (bus_if.if2dec_vld_o && bus_if.if2dec_rdy_i) begin
      e = exp_q.pop_front();
      chk("out_pc", bus_if.if2dec_pc_o, e.pc);
      chk("out_instr", bus_if.if2dec_instr_o, e.instr);
      chk("out_pc_j", bus_if.if2dec_pc_j_o, e.pc_j);
      chk("out_prdt", bus_if.if2dec_prdt_taken_o, e.prdt);
    end
    if (bus_if.icache_rsp_vld_i && bus_if.icache_rsp_rdy_o) void'(pend_q.pop_front());
    if (bus_if.icache_req_vld_o && bus_if.icache_req_rdy_i) pend_q.push_back(bus_if.icache_req_addr_o);
  endtask

  task automatic tick();
    drive();
    #1;
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    jump_flag = 1'b0;
    hold      = 1'b0;
    rdy_en    = 1'b1;
    pend_q.delete();
    exp_q.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [5];
    logic [31:0] gpc;
    logic        gtk;
    int          gn;
    bit          seen;

    vecs[0] = '{32'hFE00_0CE3, 1'b1, 32'h8000_0000};  // beq -8
    vecs[1] = '{32'h0000_0863, 1'b0, 32'h0};          // beq +16
    vecs[2] = '{32'h0200_006F, 1'b1, 32'h8000_0028};  // jal +0x20
    vecs[3] = '{32'hFE00_1EE3, 1'b1, 32'h8000_0004};  // bne -4
    vecs[4] = '{32'hFFF0_0013, 1'b0, 32'h0};          // addi -1, bit31 set
    for (int i = 0; i < 5; i++) vecs[i].taken = vecs[i].taken & PRDT_EN;

    tests = 0; fails = 0;
    rst = 1'b0; jump_flag = 1'b0; jump_pc = 32'h0; hold = 1'b0; rdy_en = 1'b1;
    wrap_jump = 1'b0; wrap_jpc = 32'h0;
    ov_addr = 32'h1; ov_instr = 32'h0;
    wrap_if.icache_req_rdy_i   = 1'b1;
    wrap_if.icache_rsp_vld_i   = 1'b0;
    wrap_if.icache_rsp_instr_i = 32'h0;
    wrap_if.if2dec_rdy_i       = 1'b0;
    drive();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_vld", bus_if.icache_req_vld_o, 0);
    chk("rst_rsp_rdy", bus_if.icache_rsp_rdy_o, 0);
    chk("rst_out_vld", bus_if.if2dec_vld_o, 0);
    chk("rst_instr", bus_if.if2dec_instr_o, 0);
    chk("rst_pc", bus_if.if2dec_pc_o, 0);
    chk("rst_pc_j", bus_if.if2dec_pc_j_o, 0);
    chk("rst_prdt", bus_if.if2dec_prdt_taken_o, 0);

    rst = 1'b1;
    #1;
    chk("first_req_vld", bus_if.icache_req_vld_o, 1);
    chk("first_req_addr", bus_if.icache_req_addr_o, 32'h8000_0000);
    chk("wrap_first_addr", wrap_if.icache_req_addr_o, 32'hFFFF_FFFC);

    for (int k = 0; k < 16; k++) push_exp(32'h8000_0000 + 32'(4 * k), 1'b0, 1'b0);
    tick();
    chk("wrap_next_addr", wrap_if.icache_req_addr_o, 32'h0000_0000);
    repeat (7) tick();

    rdy_en = 1'b0;
    repeat (10) tick();
    chk("bp_req_vld", bus_if.icache_req_vld_o, 0);
    chk("bp_head_vld", bus_if.if2dec_vld_o, 1);
    chk("bp_head_pc", bus_if.if2dec_pc_o, exp_q[0].pc);
    rdy_en = 1'b1;
    drain(100);

    do_reset();
    hold = 1'b1;
    repeat (4) tick();
    chk("kill_credit_stop", bus_if.icache_req_vld_o, 0);
    for (int k = 0; k < 4; k++) push_exp(32'h8000_0100 + 32'(4 * k), 1'b0, 1'b0);
    jump_flag = 1'b1;
    jump_pc   = 32'h8000_0100;
    tick();
    jump_flag = 1'b0;
    chk("jump_addr", bus_if.icache_req_addr_o, 32'h8000_0100);
    hold = 1'b0;
    drain(60);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      ov_addr  = 32'h8000_0008;
      ov_instr = vecs[v].instr;
      gpc = 32'h8000_0000;
      gn  = 0;
      while (gn < 6) begin
        gtk = (gpc == 32'h8000_0008) && vecs[v].taken;
        push_exp(gpc, 1'b0, gtk);
        gn++;
        if (gtk && gn < 6) begin
          push_exp(gpc + 32'd4, 1'b1, 1'b0);
          gn++;
        end
        gpc = gtk ? vecs[v].target : gpc + 32'd4;
      end
      drain(60);
    end

    do_reset();
    ov_addr  = 32'h8000_0008;
    ov_instr = 32'hFE00_0CE3;
    push_exp(32'h8000_0000, 1'b0, 1'b0);
    push_exp(32'h8000_0004, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) push_exp(32'h8000_0200 + 32'(4 * k), 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (!hold && pend_q.size() > 0 && pend_q[0] == 32'h8000_0008) begin
        chk("sim_req_vld", bus_if.icache_req_vld_o, 1);
        jump_flag = 1'b1;
        jump_pc   = 32'h8000_0200;
        tick();
        jump_flag = 1'b0;
        chk("sim_pc", bus_if.icache_req_addr_o, 32'h8000_0200);
        seen = 1'b1;
      end else begin
        tick();
      end
    end
    if (!seen) chk("sim_branch_rsp_seen", 0, 1);
    drain(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
